// File: rtl/ship_motion_ctrl_pkg.sv
// Shared definitions for the ship motion controller.
//   ANGLE_W  : width of the heading index (32 steps)
//   q1_17_t  : signed Q1.17 sample type used for sin/cos
//   SIN_QTR  : quarter-wave sine table, k = 0..8 (k*11.25 deg), 1.0 saturated
//   state_t  : per-frame update sequence
package ship_motion_ctrl_pkg;

    localparam int ANGLE_W = 5;
    localparam int Q_W     = 18;

    typedef logic signed [Q_W-1:0] q1_17_t;

    localparam logic [16:0] SIN_QTR [0:8] = '{
        17'd0,      17'd25571,  17'd50159,  17'd72820, 17'd92682,
        17'd108981, 17'd121095, 17'd128553, 17'd131071
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROT,
        S_LUT,
        S_ACCEL,
        S_DRAG,
        S_MOVE,
        S_WRAP,
        S_PUBLISH
    } state_t;

endpackage

// File: rtl/ship_motion_ctrl_sincos_lut.sv
// Registered sin/cos of a 32-step heading, built from a quarter-wave table
// by quadrant folding. One clock of latency.
//   clk, resetN : clock, async active-low reset (resets to heading 0)
//   angle       : heading index, 0 = up, increasing clockwise
//   sin_val     : sin(angle), Q1.17
//   cos_val     : cos(angle), Q1.17
module sincos_lut
    import ship_motion_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic [ANGLE_W-1:0] angle,
    output q1_17_t             sin_val,
    output q1_17_t             cos_val
);

    logic [1:0] quad;
    logic [2:0] k;
    logic [3:0] k_rev;
    q1_17_t     mag_fwd;   // T[k]
    q1_17_t     mag_rev;   // T[8-k]
    q1_17_t     sin_d, sin_q;
    q1_17_t     cos_d, cos_q;

    assign quad  = angle[4:3];
    assign k     = angle[2:0];
    assign k_rev = 4'd8 - {1'b0, k};

    // cos(a) = sin(a + 8 steps), so each quadrant just swaps/negates the
    // forward and reversed table reads.
    always_comb begin
        mag_fwd = {1'b0, SIN_QTR[k]};
        mag_rev = {1'b0, SIN_QTR[k_rev]};
        sin_d   = sin_q;
        cos_d   = cos_q;
        case (quad)
            2'd0: begin sin_d =  mag_fwd; cos_d =  mag_rev; end
            2'd1: begin sin_d =  mag_rev; cos_d = -mag_fwd; end
            2'd2: begin sin_d = -mag_fwd; cos_d = -mag_rev; end
            default: begin sin_d = -mag_rev; cos_d =  mag_fwd; end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sin_q <= '0;
            cos_q <= 18'sd131071;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_val = sin_q;
    assign cos_val = cos_q;

endmodule

// File: rtl/ship_motion_ctrl.sv
// Per-frame motion/heading controller for the player ship sprite.
// On each frame_start it steps rotate -> table -> thrust -> drag/clamp ->
// move -> wrap -> publish, one clock each, then holds its outputs for the
// rest of the frame. load respawns the ship from any state.
//   clk, resetN            : clock, async active-low reset
//   frame_start            : one-clk pulse at start of vertical blank
//   key_left/right/thrust  : level keyboard inputs
//   load, load_x, load_y   : respawn strobe and centre position
//   topLeft_x, topLeft_y   : published sprite top-left
//   sin_val, cos_val       : published heading sin/cos, Q1.17
//   angle                  : published heading index
//   upd_done               : pulses when the outputs are republished
//   frame_missed           : pulses when frame_start arrives mid-update
module ship_motion_ctrl
    import ship_motion_ctrl_pkg::*;
#(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int SINCOS_FRACTION = 17,
    parameter int ANGLE_STEPS     = 32,
    parameter int POS_FRAC        = 8,
    parameter int ACCEL           = 64,
    parameter int DRAG_SHIFT      = 5,
    parameter int VMAX            = 1024,
    parameter int OFFSET_X        = 16,
    parameter int OFFSET_Y        = 16,
    parameter int START_X         = 320,
    parameter int START_Y         = 240
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      frame_start,
    input  logic                      key_left,
    input  logic                      key_right,
    input  logic                      key_thrust,
    input  logic                      load,
    input  logic [$clog2(WIDTH)-1:0]  load_x,
    input  logic [$clog2(HEIGHT)-1:0] load_y,
    output logic [$clog2(WIDTH)-1:0]  topLeft_x,
    output logic [$clog2(HEIGHT)-1:0] topLeft_y,
    output logic signed [17:0]        sin_val,
    output logic signed [17:0]        cos_val,
    output logic [ANGLE_W-1:0]        angle,
    output logic                      upd_done,
    output logic                      frame_missed
);

    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int XPW = XW + POS_FRAC;
    localparam int YPW = YW + POS_FRAC;
    localparam int MXW = XPW + 1;            // signed move result, may be out of range
    localparam int MYW = YPW + 1;
    localparam int VW  = $clog2(VMAX) + 2;
    localparam int PW  = Q_W + $clog2(ACCEL) + 2;

    localparam logic [XPW-1:0]        START_PX = XPW'(START_X * (2 ** POS_FRAC));
    localparam logic [YPW-1:0]        START_PY = YPW'(START_Y * (2 ** POS_FRAC));
    localparam logic signed [MXW-1:0] X_SPAN   = MXW'(WIDTH * (2 ** POS_FRAC));
    localparam logic signed [MYW-1:0] Y_SPAN   = MYW'(HEIGHT * (2 ** POS_FRAC));
    localparam logic signed [VW-1:0]  VMAX_C   = VW'(VMAX);
    localparam logic signed [PW-1:0]  ACCEL_C  = PW'(ACCEL);
    localparam logic [XW-1:0]         OFS_X    = XW'(OFFSET_X);
    localparam logic [YW-1:0]         OFS_Y    = YW'(OFFSET_Y);
    localparam logic [XW-1:0]         WRAP_X   = XW'(WIDTH - OFFSET_X);
    localparam logic [YW-1:0]         WRAP_Y   = YW'(HEIGHT - OFFSET_Y);

    state_t                  state_d, state_q;
    logic [ANGLE_W-1:0]      heading_d, heading_q;
    logic signed [VW-1:0]    vx_d, vx_q, vy_d, vy_q;
    logic signed [VW-1:0]    vx_dr, vy_dr;
    logic [XPW-1:0]          pos_x_d, pos_x_q;
    logic [YPW-1:0]          pos_y_d, pos_y_q;
    logic signed [MXW-1:0]   mv_x_d, mv_x_q;
    logic signed [MYW-1:0]   mv_y_d, mv_y_q;
    logic [XW-1:0]           tl_x_d, tl_x_q, ix;
    logic [YW-1:0]           tl_y_d, tl_y_q, iy;
    q1_17_t                  sin_d, sin_q, cos_d, cos_q;
    q1_17_t                  sin_lut, cos_lut;
    logic [ANGLE_W-1:0]      angle_pub_d, angle_pub_q;
    logic                    upd_done_d, upd_done_q;
    logic                    frame_missed_d, frame_missed_q;
    logic signed [PW-1:0]    sin_ext, cos_ext, prod_x, prod_y;

    // The table is fed the next heading, so its registered output always
    // matches heading_q -- this also covers the respawn path, where the
    // publish follows the load by a single clock.
    sincos_lut u_lut (
        .clk     (clk),
        .resetN  (resetN),
        .angle   (heading_d),
        .sin_val (sin_lut),
        .cos_val (cos_lut)
    );

    assign ix      = pos_x_q[XPW-1:POS_FRAC];
    assign iy      = pos_y_q[YPW-1:POS_FRAC];
    assign sin_ext = {{(PW-Q_W){sin_lut[Q_W-1]}}, sin_lut};
    assign cos_ext = {{(PW-Q_W){cos_lut[Q_W-1]}}, cos_lut};
    assign prod_x  = sin_ext * ACCEL_C;
    assign prod_y  = -cos_ext * ACCEL_C;     // screen y grows downward
    assign vx_dr   = vx_q - (vx_q >>> DRAG_SHIFT);
    assign vy_dr   = vy_q - (vy_q >>> DRAG_SHIFT);

    function automatic logic signed [VW-1:0] vclamp(input logic signed [VW-1:0] v);
        if (v > VMAX_C)       return VMAX_C;
        else if (v < -VMAX_C) return -VMAX_C;
        else                  return v;
    endfunction

    always_comb begin
        state_d        = state_q;
        heading_d      = heading_q;
        vx_d           = vx_q;
        vy_d           = vy_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        mv_x_d         = mv_x_q;
        mv_y_d         = mv_y_q;
        tl_x_d         = tl_x_q;
        tl_y_d         = tl_y_q;
        sin_d          = sin_q;
        cos_d          = cos_q;
        angle_pub_d    = angle_pub_q;
        upd_done_d     = 1'b0;
        frame_missed_d = frame_start && (state_q != S_IDLE) && !load;

        case (state_q)
            S_IDLE: if (frame_start) state_d = S_ROT;
            S_ROT: begin
                if (key_right && !key_left)      heading_d = heading_q + ANGLE_W'(1);
                else if (key_left && !key_right) heading_d = heading_q - ANGLE_W'(1);
                state_d = S_LUT;
            end
            S_LUT: state_d = S_ACCEL;
            S_ACCEL: begin
                if (key_thrust) begin
                    vx_d = vx_q + VW'(prod_x >>> SINCOS_FRACTION);
                    vy_d = vy_q + VW'(prod_y >>> SINCOS_FRACTION);
                end
                state_d = S_DRAG;
            end
            S_DRAG: begin
                vx_d    = vclamp(vx_dr);
                vy_d    = vclamp(vy_dr);
                state_d = S_MOVE;
            end
            S_MOVE: begin
                mv_x_d  = $signed({1'b0, pos_x_q}) + {{(MXW-VW){vx_q[VW-1]}}, vx_q};
                mv_y_d  = $signed({1'b0, pos_y_q}) + {{(MYW-VW){vy_q[VW-1]}}, vy_q};
                state_d = S_WRAP;
            end
            S_WRAP: begin
                // |v| <= VMAX < span, so one correction always lands in range
                if (mv_x_q < 0)            pos_x_d = XPW'(mv_x_q + X_SPAN);
                else if (mv_x_q >= X_SPAN) pos_x_d = XPW'(mv_x_q - X_SPAN);
                else                       pos_x_d = XPW'(mv_x_q);
                if (mv_y_q < 0)            pos_y_d = YPW'(mv_y_q + Y_SPAN);
                else if (mv_y_q >= Y_SPAN) pos_y_d = YPW'(mv_y_q - Y_SPAN);
                else                       pos_y_d = YPW'(mv_y_q);
                state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                tl_x_d      = (ix >= OFS_X) ? ix - OFS_X : ix + WRAP_X;
                tl_y_d      = (iy >= OFS_Y) ? iy - OFS_Y : iy + WRAP_Y;
                sin_d       = sin_lut;
                cos_d       = cos_lut;
                angle_pub_d = heading_q;
                upd_done_d  = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Respawn wins over everything, including a publish in flight.
        if (load) begin
            state_d     = S_PUBLISH;
            heading_d   = '0;
            vx_d        = '0;
            vy_d        = '0;
            pos_x_d     = {load_x, {POS_FRAC{1'b0}}};
            pos_y_d     = {load_y, {POS_FRAC{1'b0}}};
            tl_x_d      = tl_x_q;
            tl_y_d      = tl_y_q;
            sin_d       = sin_q;
            cos_d       = cos_q;
            angle_pub_d = angle_pub_q;
            upd_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= S_IDLE;
            heading_q      <= '0;
            vx_q           <= '0;
            vy_q           <= '0;
            pos_x_q        <= START_PX;
            pos_y_q        <= START_PY;
            mv_x_q         <= '0;
            mv_y_q         <= '0;
            tl_x_q         <= XW'(START_X - OFFSET_X);
            tl_y_q         <= YW'(START_Y - OFFSET_Y);
            sin_q          <= '0;
            cos_q          <= 18'sd131071;
            angle_pub_q    <= '0;
            upd_done_q     <= 1'b0;
            frame_missed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            heading_q      <= heading_d;
            vx_q           <= vx_d;
            vy_q           <= vy_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            mv_x_q         <= mv_x_d;
            mv_y_q         <= mv_y_d;
            tl_x_q         <= tl_x_d;
            tl_y_q         <= tl_y_d;
            sin_q          <= sin_d;
            cos_q          <= cos_d;
            angle_pub_q    <= angle_pub_d;
            upd_done_q     <= upd_done_d;
            frame_missed_q <= frame_missed_d;
        end
    end

    assign topLeft_x    = tl_x_q;
    assign topLeft_y    = tl_y_q;
    assign sin_val      = sin_q;
    assign cos_val      = cos_q;
    assign angle        = angle_pub_q;
    assign upd_done     = upd_done_q;
    assign frame_missed = frame_missed_q;

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Scoreboard bench for ship_motion_ctrl: a per-frame integer model pushes the
// expected publish (and its due cycle) when stimulus is driven; a negedge
// monitor pops and compares on every upd_done.
module tb_ship_motion_ctrl;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              frame_start = 1'b0;
    logic              key_left = 1'b0, key_right = 1'b0, key_thrust = 1'b0;
    logic              load = 1'b0;
    logic [9:0]        load_x = '0;
    logic [8:0]        load_y = '0;
    logic [9:0]        topLeft_x;
    logic [8:0]        topLeft_y;
    logic signed [17:0] sin_val, cos_val;
    logic [4:0]        angle;
    logic              upd_done, frame_missed;

    ship_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start),
        .key_left(key_left), .key_right(key_right), .key_thrust(key_thrust),
        .load(load), .load_x(load_x), .load_y(load_y),
        .topLeft_x(topLeft_x), .topLeft_y(topLeft_y),
        .sin_val(sin_val), .cos_val(cos_val), .angle(angle),
        .upd_done(upd_done), .frame_missed(frame_missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     tlx, tly, sn, cs, ang, vx, vy;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     n_run = 0, n_fail = 0;
    int     n_upd = 0, n_missed = 0;
    longint cyc = 0;
    int     prev_tlx = -1;
    bit     wrap_seen = 1'b0;
    bit     wrap_watch = 1'b0;

    int sin_t [9] = '{0, 25571, 50159, 72820, 92682, 108981, 121095, 128553, 131071};
    int m_ang, m_vx, m_vy, m_px, m_py;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int msin(input int a);
        if (a <= 8)       return sin_t[a];
        else if (a <= 16) return sin_t[16 - a];
        else if (a <= 24) return -sin_t[a - 16];
        else              return -sin_t[32 - a];
    endfunction

    function automatic int mcos(input int a);
        return msin((a + 8) % 32);
    endfunction

    function automatic int vclip(input int v);
        return (v > 1024) ? 1024 : ((v < -1024) ? -1024 : v);
    endfunction

    task automatic model_reset();
        m_ang = 0; m_vx = 0; m_vy = 0; m_px = 320 * 256; m_py = 240 * 256;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit t);
        if (r && !l)      m_ang = (m_ang + 1) % 32;
        else if (l && !r) m_ang = (m_ang + 31) % 32;
        if (t) begin
            m_vx = m_vx + ((msin(m_ang) * 64) >>> 17);
            m_vy = m_vy + ((-mcos(m_ang) * 64) >>> 17);
        end
        m_vx = vclip(m_vx - (m_vx >>> 5));
        m_vy = vclip(m_vy - (m_vy >>> 5));
        m_px = m_px + m_vx;
        m_py = m_py + m_vy;
        if (m_px < 0) m_px += 640 * 256; else if (m_px >= 640 * 256) m_px -= 640 * 256;
        if (m_py < 0) m_py += 480 * 256; else if (m_py >= 480 * 256) m_py -= 480 * 256;
    endtask

    task automatic push_exp(input longint due);
        exp_t e;
        e.tlx = m_px / 256 - 16; if (e.tlx < 0) e.tlx += 640;
        e.tly = m_py / 256 - 16; if (e.tly < 0) e.tly += 480;
        e.sn  = msin(m_ang);
        e.cs  = mcos(m_ang);
        e.ang = m_ang;
        e.vx  = m_vx;
        e.vy  = m_vy;
        e.due = due;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (frame_missed) n_missed++;
            if (upd_done) begin
                n_upd++;
                if (sb.size() == 0) chk("unexpected_upd", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("topLeft_x", topLeft_x, e.tlx);
                    chk("topLeft_y", topLeft_y, e.tly);
                    chk("sin_val", sin_val, e.sn);
                    chk("cos_val", cos_val, e.cs);
                    chk("angle", angle, e.ang);
                    chk("vx", dut.vx_q, e.vx);
                    chk("vy", dut.vy_q, e.vy);
                    chk("latency", cyc, e.due);
                end
                if (wrap_watch) begin
                    chk("tlx_in_range", topLeft_x < 10'd640, 1);
                    if (prev_tlx == 623 && topLeft_x >= 624 && topLeft_x <= 627) wrap_seen = 1'b1;
                    prev_tlx = topLeft_x;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic frame(input bit l, input bit r, input bit t);
        @(negedge clk);
        key_left = l; key_right = r; key_thrust = t;
        model_frame(l, r, t);
        push_exp(cyc + 8);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle();
    endtask

    task automatic do_load(input int x, input int y, input bit with_fs);
        @(negedge clk);
        load = 1'b1; load_x = 10'(x); load_y = 9'(y); frame_start = with_fs;
        m_ang = 0; m_vx = 0; m_vy = 0; m_px = x * 256; m_py = y * 256;
        push_exp(cyc + 2);
        @(negedge clk);
        load = 1'b0; frame_start = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0; key_left = 0; key_right = 0; key_thrust = 0;
        repeat (2) @(negedge clk);
        model_reset();
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int m0, u0;
        model_reset();
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_topLeft_x", topLeft_x, 304);
        chk("rst_topLeft_y", topLeft_y, 224);
        chk("rst_sin", sin_val, 0);
        chk("rst_cos", cos_val, 131071);
        chk("rst_angle", angle, 0);
        chk("rst_upd_done", upd_done, 0);
        chk("rst_frame_missed", frame_missed, 0);

        repeat (3) frame(0, 0, 0);
        repeat (8) frame(0, 1, 0);
        chk("angle_after_right8", angle, 8);

        do_reset();
        repeat (9) frame(1, 0, 0);
        chk("angle_after_left9", angle, 23);
        repeat (2) frame(1, 1, 0);
        chk("angle_both_keys", angle, 23);

        do_reset();
        frame(0, 0, 1);
        chk("thrust1_topLeft_y", topLeft_y, 223);

        do_load(639, 100, 1'b0);
        repeat (8) frame(0, 1, 0);
        prev_tlx = topLeft_x;
        wrap_watch = 1'b1;
        repeat (200) frame(0, 0, 1);
        wrap_watch = 1'b0;
        chk("wrap_seen", wrap_seen, 1);
        chk("vx_saturated", dut.vx_q, 1024);
        repeat (60) frame(0, 0, 0);

        // second frame_start lands while the first update is still running
        key_thrust = 0;
        m0 = n_missed; u0 = n_upd;
        @(negedge clk);
        model_frame(0, 0, 0);
        push_exp(cyc + 8);
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("missed_pulses", n_missed - m0, 1);
        chk("missed_upd_count", n_upd - u0, 1);

        // respawn while the frame update sits in ACCEL
        key_thrust = 1;
        u0 = n_upd;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; load_x = 10'd100; load_y = 9'd8;
        m_ang = 0; m_vx = 0; m_vy = 0; m_px = 100 * 256; m_py = 8 * 256;
        push_exp(cyc + 2);
        @(negedge clk); load = 1'b0;
        key_thrust = 0;
        wait_idle();
        repeat (12) @(negedge clk);
        chk("midload_upd_count", n_upd - u0, 1);

        // load and frame_start on the same clock: frame dropped silently
        m0 = n_missed; u0 = n_upd;
        do_load(5, 470, 1'b1);
        repeat (12) @(negedge clk);
        chk("load_fs_missed", n_missed - m0, 0);
        chk("load_fs_upd_count", n_upd - u0, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ship_motion_ctrl.md
Name: ship_motion_ctrl

Overview:
Per-frame motion and heading controller for one rotating sprite (player ship). It sits directly upstream of the sprite draw stage. Once per frame it integrates keyboard rotate/thrust into angle, velocity and position. It then publishes topLeft_x/topLeft_y and the Q1.17 sin_val/cos_val that the draw stage consumes, and holds them stable for the whole following frame.

Parameters:
WIDTH, 640, screen width in pixels
HEIGHT, 480, screen height in pixels
SINCOS_FRACTION, 17, fraction bits of sin_val/cos_val
ANGLE_STEPS, 32, heading resolution; fixed at 32 (11.25 deg per step)
POS_FRAC, 8, fraction bits of position and velocity
ACCEL, 64, thrust per frame in velocity LSBs
DRAG_SHIFT, 5, drag: v -= v>>>DRAG_SHIFT
VMAX, 1024, velocity clamp magnitude (LSBs); must be < WIDTH<<POS_FRAC
OFFSET_X, 16, sprite rotation-centre offset x
OFFSET_Y, 16, sprite rotation-centre offset y
START_X, 320, reset centre x
START_Y, 240, reset centre y

Ports:
clk  in  1  clock
resetN  in  1  asynchronous active-low reset
frame_start  in  1  one-clk pulse at start of vertical blank
key_left  in  1  rotate counter-clockwise (level)
key_right  in  1  rotate clockwise (level)
key_thrust  in  1  accelerate along heading (level)
load  in  1  one-clk respawn strobe
load_x  in  $clog2(WIDTH)  respawn centre x
load_y  in  $clog2(HEIGHT)  respawn centre y
topLeft_x  out  $clog2(WIDTH)  sprite top-left x
topLeft_y  out  $clog2(HEIGHT)  sprite top-left y
sin_val  out  18 signed  sin(heading), Q1.17
cos_val  out  18 signed  cos(heading), Q1.17
angle  out  5  heading index, 0 = up, increasing clockwise
upd_done  out  1  one-clk pulse when outputs are republished
frame_missed  out  1  one-clk pulse when frame_start is ignored

Behaviour:
- Reset (async): angle=0; v=0; position=START<<POS_FRAC; topLeft_x=START_X-OFFSET_X; topLeft_y=START_Y-OFFSET_Y; sin_val=0; cos_val=131071; upd_done=0; frame_missed=0; FSM=IDLE.
- FSM: IDLE -> ROT -> LUT -> ACCEL -> DRAG -> MOVE -> WRAP -> PUBLISH -> IDLE, one clk per state. Leave IDLE only on frame_start.
- Latency: outputs and upd_done change on the 7th rising edge after the edge that samples frame_start.
- Outputs change only in PUBLISH, so they are stable between updates.
- frame_start outside IDLE: ignored, frame_missed pulses 1 clk.
- ROT: right&!left: angle+1 mod 32. left&!right: angle-1 mod 32. Both or neither: unchanged.
- LUT: registered quarter-wave table, entries k=0..8: 0, 25571, 50159, 72820, 92682, 108981, 121095, 128553, 131071 (1.0 saturated). Quadrant folding gives sin and cos of the new angle. Exact: a=0 -> (0,131071); a=8 -> (131071,0); a=16 -> (0,-131071); a=24 -> (-131071,0).
- ACCEL, only if key_thrust (sampled in ACCEL):
  - vx += (sin*ACCEL)>>>SINCOS_FRACTION
  - vy += (-cos*ACCEL)>>>SINCOS_FRACTION
  - Arithmetic shift (floor).
- DRAG: each component v -= v>>>DRAG_SHIFT. Small positive residues may persist; this is accepted.
- Clamp: each component clamped to [-VMAX, +VMAX] in the DRAG state.
- MOVE: pos += sign-extended v.
- WRAP: if pos<0, add WIDTH<<POS_FRAC (HEIGHT for y); if pos>=WIDTH<<POS_FRAC, subtract it. One correction suffices given VMAX.
- PUBLISH: topLeft = pos integer part - OFFSET, modulo WIDTH/HEIGHT (add WIDTH/HEIGHT if negative). Also drive sin/cos/angle registers; upd_done=1.
- load: highest priority in any state. Sets pos=load<<POS_FRAC, v=0, angle=0, FSM=PUBLISH. Next edge republishes with sin=0, cos=131071. A frame_start on the same clk as load is dropped without a frame_missed pulse.
- Internal widths:
  - pos_x unsigned $clog2(WIDTH)+POS_FRAC; pos_y unsigned $clog2(HEIGHT)+POS_FRAC.
  - Velocity signed $clog2(VMAX)+2.
  - Products use 18+$clog2(ACCEL)+2 bits.

Decomposition:
- Shared package: quarter-wave sin table constant; ANGLE_W=5; Q1.17 typedef (signed [17:0]); FSM state enum.
- One sub-module, sincos_lut: angle in, registered sin/cos out, 1-clk latency.

Test Plan:
- Reset release, no keys, 3 frame_start pulses -> topLeft=(304,224), angle=0, sin=0, cos=131071, upd_done 7 clk after each pulse.
- key_right held 8 frames -> angle=8, sin=131071, cos=0. Reset, then key_left held 9 frames -> angle=23. Both keys held -> angle unchanged.
- From reset, key_thrust 1 frame at angle 0 -> vy=-62 (-64 thrust, +2 drag), vx=0, topLeft_y=223, topLeft_x=304.
- load x=639,y=100; rotate to angle 8; thrust until x integer passes 639 -> centre x goes to 0..3, never >=640; topLeft_x goes from 623 to 624..627.
- Thrust held 200 frames at angle 8 -> vx saturates at <=1024, never exceeds; after release vx decays monotonically.
- frame_start re-pulsed 3 clk after first -> frame_missed=1 for 1 clk, single upd_done. load mid-FSM (ACCEL state) -> next edge publishes load position with angle 0, v=0.
